// File: rtl/audio_i2s_dac_tx.sv
// I2S master transmitter: generates bclk/daclrc, pops one stereo sample per frame from a show-ahead FIFO
// and shifts it MSB-first onto dacdat. Build option UNDERFLOW_HOLD_EN repeats the last sample on underflow.
module audio_i2s_dac_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32,
  parameter int SAMPLE_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  underflow_clr,
  output logic                  underflow,
  output logic                  busy,
  output logic                  bclk,
  output logic                  daclrc,
  output logic                  dacdat
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int POS_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_SLOT = POS_W'(SLOT_BITS);
  localparam logic [POS_W-1:0] POS_MSB  = POS_W'(SAMPLE_W);

  if (SAMPLE_W > SLOT_BITS - 1) begin : g_bad_sample_w
    $error("SAMPLE_W must not exceed SLOT_BITS-1");
  end
  if (BCLK_HALF < 1) begin : g_bad_bclk_half
    $error("BCLK_HALF must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [POS_W-1:0]      pos;         // frame bit position emitted at the next fall event
  logic [2*SAMPLE_W-1:0] sample;
  logic                  fall, boundary, stop, pop, uf_event;
  logic                  slot_right, bit_next;
  logic [POS_W-1:0]      slot_k;
  logic [SAMPLE_W-1:0]   chan, chan_shift;

  assign fall     = (state == RUN) && bclk && (div_cnt == DIV_LAST);
  assign boundary = fall && (pos == '0);
  assign stop     = boundary && !en;
  assign pop      = boundary && en && !fifo_empty;
  assign uf_event = boundary && en && fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)   state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The pop strobe is combinational so the FIFO head is consumed on the same edge that captures it.
  always_comb begin
    busy    = (state == RUN);
    fifo_rd = pop;
  end

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    slot_right = (pos >= POS_SLOT);
    slot_k     = slot_right ? pos - POS_SLOT : pos;
    chan       = slot_right ? sample[SAMPLE_W-1:0] : sample[2*SAMPLE_W-1:SAMPLE_W];
    chan_shift = chan << (slot_k - POS_W'(1));
    bit_next   = 1'b0;
    if (slot_k != '0 && slot_k <= POS_MSB) bit_next = chan_shift[SAMPLE_W-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      pos     <= '0;
      daclrc  <= 1'b0;
      dacdat  <= 1'b0;
    end else if (state == IDLE || stop) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      pos     <= '0;
      daclrc  <= 1'b0;
      dacdat  <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) begin
        daclrc <= slot_right;
        dacdat <= bit_next;
        pos    <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
      end
    end
  end

  // NOTE: the sample register is reset because the hold build replays it before any real sample arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample <= '0;
    end else if (pop) begin
      sample <= fifo_data;
    end else if (uf_event) begin
`ifdef UNDERFLOW_HOLD_EN
      sample <= sample;
`else
      sample <= '0;
`endif
    end
  end

  // A new underflow outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               underflow <= 1'b0;
    else if (uf_event)      underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

endmodule
